// File: rtl/dc_ipu_filter_pkg.sv
// Shared types and helpers for the IPU scaler filter weight stage.
// Contents:
//   filt_mode_e  - kernel select carried with every beat
//   filt_one()   - weight value of 1.0 for a given number of fraction bits
package dc_ipu_filter_pkg;

  typedef enum logic [1:0] {
    FILT_NEAREST  = 2'd0,
    FILT_BILINEAR = 2'd1,
    FILT_CUBIC    = 2'd2,
    FILT_RSVD     = 2'd3   // decoded as bilinear
  } filt_mode_e;

  localparam int FILT_DEF_FRACT = 8;
  localparam int FILT_DEF_ONE   = 1 << FILT_DEF_FRACT;

  function automatic int filt_one(input int fract);
    return 1 << fract;
  endfunction

endpackage

// File: rtl/dc_ipu_filter_kernel_weights.sv
// One-axis filter weight generator: phase t in, TAPS signed weights out.
// Two registered stages, each advanced by an enable from the parent:
//   S1 : t, t^2, t^3 (unsigned, WEIGHT_FRACT_WIDTH fraction bits, floored)
//   S2 : kernel weights, saturated to WEIGHT_WIDTH
// Ports:
//   clk, nreset (async low), clr (sync flush)
//   en1_i, en2_i : stage load enables
//   t_i          : aligned phase, mode_i : kernel select (same beat as t_i)
//   weights_o    : packed weights, index 0 at LSBs
module dc_ipu_filter_kernel_weights
  import dc_ipu_filter_pkg::*;
#(
  parameter int TAPS               = 4,
  parameter int WEIGHT_WIDTH       = 12,
  parameter int WEIGHT_FRACT_WIDTH = 8
) (
  input  logic                                   clk,
  input  logic                                   nreset,
  input  logic                                   clr,
  input  logic                                   en1_i,
  input  logic                                   en2_i,
  input  logic [WEIGHT_FRACT_WIDTH-1:0]          t_i,
  input  logic [1:0]                             mode_i,
  output logic [TAPS-1:0][WEIGHT_WIDTH-1:0]      weights_o
);

  localparam int F  = WEIGHT_FRACT_WIDTH;
  // Internal signed width: wide enough for the cubic numerators and for
  // every value that could need clamping into WEIGHT_WIDTH.
  localparam int IW = (F + 5 > WEIGHT_WIDTH + 1) ? F + 5 : WEIGHT_WIDTH + 1;
  localparam logic signed [IW-1:0] ONE  = IW'(filt_one(F));
  localparam logic signed [IW-1:0] WMAX = IW'((1 << (WEIGHT_WIDTH - 1)) - 1);
  localparam logic signed [IW-1:0] WMIN = IW'(-(1 << (WEIGHT_WIDTH - 1)));

  // S1: powers from full-precision products, floored back to F fraction bits
  logic [2*F-1:0] sq;
  logic [3*F-1:0] cu;
  logic [F-1:0]   t1_q, t2_q, t3_q;
  logic [1:0]     mode1_q;

  assign sq = {{F{1'b0}}, t_i} * {{F{1'b0}}, t_i};
  assign cu = {{F{1'b0}}, sq} * {{2*F{1'b0}}, t_i};

  // S2: weights
  logic signed [IW-1:0] ts, t2s, t3s;
  logic signed [IW-1:0] raw [TAPS];
  logic [TAPS-1:0][WEIGHT_WIDTH-1:0] w_d, w_q;
  filt_mode_e md;
  logic       hi;

  assign ts  = $signed({{(IW-F){1'b0}}, t1_q});
  assign t2s = $signed({{(IW-F){1'b0}}, t2_q});
  assign t3s = $signed({{(IW-F){1'b0}}, t3_q});
  assign md  = filt_mode_e'(mode1_q);
  assign hi  = t1_q[F-1];   // t >= 0.5

  function automatic logic [WEIGHT_WIDTH-1:0] sat(input logic signed [IW-1:0] v);
    if (v > WMAX)      return WMAX[WEIGHT_WIDTH-1:0];
    else if (v < WMIN) return WMIN[WEIGHT_WIDTH-1:0];
    else               return v[WEIGHT_WIDTH-1:0];
  endfunction

  generate
    if (TAPS == 4) begin : g_t4
      logic signed [IW-1:0] c0, c1, c2, c3;
      // Catmull-Rom (a = -0.5); w1 absorbs the rounding so the sum is exactly 1.0
      assign c0 = ((t2s <<< 1) - t3s - ts) >>> 1;
      assign c2 = ((t2s <<< 2) - t3s - (t3s <<< 1) + ts) >>> 1;
      assign c3 = (t3s - t2s) >>> 1;
      assign c1 = ONE - c0 - c2 - c3;

      always_comb begin
        for (int i = 0; i < TAPS; i++) raw[i] = '0;
        case (md)
          FILT_NEAREST: raw[hi ? 2 : 1] = ONE;
          FILT_CUBIC: begin
            raw[0] = c0; raw[1] = c1; raw[2] = c2; raw[3] = c3;
          end
          default: begin
            raw[1] = ONE - ts; raw[2] = ts;
          end
        endcase
      end
    end else begin : g_t2
      // two taps: cubic falls back to bilinear
      always_comb begin
        for (int i = 0; i < TAPS; i++) raw[i] = '0;
        case (md)
          FILT_NEAREST: raw[hi ? 1 : 0] = ONE;
          default: begin
            raw[0] = ONE - ts; raw[1] = ts;
          end
        endcase
      end
    end
  endgenerate

  always_comb begin
    w_d = '0;
    for (int i = 0; i < TAPS; i++) w_d[i] = sat(raw[i]);
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      t1_q <= '0; t2_q <= '0; t3_q <= '0; mode1_q <= '0; w_q <= '0;
    end else if (clr) begin
      t1_q <= '0; t2_q <= '0; t3_q <= '0; mode1_q <= '0; w_q <= '0;
    end else begin
      if (en1_i) begin
        t1_q    <= t_i;
        t2_q    <= F'(sq >> F);
        t3_q    <= F'(cu >> (2 * F));
        mode1_q <= mode_i;
      end
      if (en2_i) w_q <= w_d;
    end
  end

  assign weights_o = w_q;

endmodule

// File: rtl/dc_ipu_filter_weight_stage.sv
// IPU scaler filter: weight generation and texel alignment stage.
// Accepts a TAPS x TAPS x CHANNELS texel window ([y][x][ch], row-major) with
// x/y phases and a kernel mode; emits the same window 3 cycles later together
// with per-axis signed weights.
// Pipeline: S0 (skid + phase align) -> S1 (powers) -> S2 (weights / output).
// Ports:
//   clk, nreset (async low), clr (sync flush, wins over a handshake)
//   in_valid/in_ready/in_texels/coeff_x/coeff_y/mode : input beat
//   out_valid/out_ready/out_texels/out_weights_x/out_weights_y : output beat
module dc_ipu_filter_weight_stage
  import dc_ipu_filter_pkg::*;
#(
  parameter int TAPS               = 4,
  parameter int CHANNELS           = 3,
  parameter int RGB_WIDTH          = 8,
  parameter int COEFF_WIDTH        = 6,
  parameter int WEIGHT_WIDTH       = 12,
  parameter int WEIGHT_FRACT_WIDTH = 8
) (
  input  logic                                      clk,
  input  logic                                      nreset,
  input  logic                                      clr,
  input  logic [1:0]                                mode,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [TAPS*TAPS*CHANNELS*RGB_WIDTH-1:0]   in_texels,
  input  logic [COEFF_WIDTH-1:0]                    coeff_x,
  input  logic [COEFF_WIDTH-1:0]                    coeff_y,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [TAPS*TAPS*CHANNELS*RGB_WIDTH-1:0]   out_texels,
  output logic [TAPS*WEIGHT_WIDTH-1:0]              out_weights_x,
  output logic [TAPS*WEIGHT_WIDTH-1:0]              out_weights_y
);

  localparam int TEX_W = TAPS * TAPS * CHANNELS * RGB_WIDTH;
  localparam int F     = WEIGHT_FRACT_WIDTH;

  // Phase alignment: left-justify coeff into F fraction bits
  logic [F-1:0] tx_al, ty_al;
  generate
    if (COEFF_WIDTH >= F) begin : g_drop
      assign tx_al = coeff_x[COEFF_WIDTH-1 -: F];
      assign ty_al = coeff_y[COEFF_WIDTH-1 -: F];
    end else begin : g_pad
      assign tx_al = {coeff_x, {(F-COEFF_WIDTH){1'b0}}};
      assign ty_al = {coeff_y, {(F-COEFF_WIDTH){1'b0}}};
    end
  endgenerate

  logic             in_rdy_q, in_rdy_d;
  logic             s0_vld_q, s0_vld_d, sk_vld_q, sk_vld_d;
  logic             s1_vld_q, s1_vld_d, out_vld_q, out_vld_d;
  logic [TEX_W-1:0] s0_tex_q, s0_tex_d, sk_tex_q, sk_tex_d;
  logic [TEX_W-1:0] s1_tex_q, s1_tex_d, out_tex_q, out_tex_d;
  logic [F-1:0]     s0_tx_q, s0_tx_d, s0_ty_q, s0_ty_d;
  logic [F-1:0]     sk_tx_q, sk_tx_d, sk_ty_q, sk_ty_d;
  logic [1:0]       s0_mode_q, s0_mode_d, sk_mode_q, sk_mode_d;

  logic s2_en, s1_en, s0_free, accept;

  // A stage loads when its slot is empty or its occupant is leaving
  assign s2_en   = !out_vld_q || out_ready;
  assign s1_en   = !s1_vld_q || s2_en;
  assign s0_free = !s0_vld_q || s1_en;
  assign accept  = in_valid && in_rdy_q;

  always_comb begin
    s0_vld_d  = s0_vld_q;  sk_vld_d  = sk_vld_q;
    s0_tex_d  = s0_tex_q;  sk_tex_d  = sk_tex_q;
    s0_tx_d   = s0_tx_q;   sk_tx_d   = sk_tx_q;
    s0_ty_d   = s0_ty_q;   sk_ty_d   = sk_ty_q;
    s0_mode_d = s0_mode_q; sk_mode_d = sk_mode_q;
    s1_vld_d  = s1_vld_q;  s1_tex_d  = s1_tex_q;
    out_vld_d = out_vld_q; out_tex_d = out_tex_q;

    // in_ready is low whenever the skid is full, so accept and a skid
    // occupant are mutually exclusive.
    if (sk_vld_q) begin
      if (s0_free) begin
        s0_vld_d = 1'b1; sk_vld_d = 1'b0;
        s0_tex_d = sk_tex_q; s0_tx_d = sk_tx_q; s0_ty_d = sk_ty_q; s0_mode_d = sk_mode_q;
      end
    end else if (accept) begin
      if (s0_free) begin
        s0_vld_d = 1'b1;
        s0_tex_d = in_texels; s0_tx_d = tx_al; s0_ty_d = ty_al; s0_mode_d = mode;
      end else begin
        sk_vld_d = 1'b1;
        sk_tex_d = in_texels; sk_tx_d = tx_al; sk_ty_d = ty_al; sk_mode_d = mode;
      end
    end else if (s1_en) begin
      s0_vld_d = 1'b0;
    end

    if (s1_en) begin s1_vld_d = s0_vld_q; s1_tex_d = s0_tex_q; end
    if (s2_en) begin out_vld_d = s1_vld_q; out_tex_d = s1_tex_q; end

    in_rdy_d = !sk_vld_d;

    if (clr) begin
      s0_vld_d = 1'b0; sk_vld_d = 1'b0; s1_vld_d = 1'b0; out_vld_d = 1'b0;
      s0_tex_d = '0; sk_tex_d = '0; s1_tex_d = '0; out_tex_d = '0;
      s0_tx_d = '0; s0_ty_d = '0; sk_tx_d = '0; sk_ty_d = '0;
      s0_mode_d = '0; sk_mode_d = '0;
      in_rdy_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      in_rdy_q <= 1'b1;
      s0_vld_q <= 1'b0; sk_vld_q <= 1'b0; s1_vld_q <= 1'b0; out_vld_q <= 1'b0;
      s0_tex_q <= '0; sk_tex_q <= '0; s1_tex_q <= '0; out_tex_q <= '0;
      s0_tx_q <= '0; s0_ty_q <= '0; sk_tx_q <= '0; sk_ty_q <= '0;
      s0_mode_q <= '0; sk_mode_q <= '0;
    end else begin
      in_rdy_q <= in_rdy_d;
      s0_vld_q <= s0_vld_d; sk_vld_q <= sk_vld_d; s1_vld_q <= s1_vld_d; out_vld_q <= out_vld_d;
      s0_tex_q <= s0_tex_d; sk_tex_q <= sk_tex_d; s1_tex_q <= s1_tex_d; out_tex_q <= out_tex_d;
      s0_tx_q <= s0_tx_d; s0_ty_q <= s0_ty_d; sk_tx_q <= sk_tx_d; sk_ty_q <= sk_ty_d;
      s0_mode_q <= s0_mode_d; sk_mode_q <= sk_mode_d;
    end
  end

  logic [TAPS-1:0][WEIGHT_WIDTH-1:0] wx, wy;

  dc_ipu_filter_kernel_weights #(
    .TAPS(TAPS), .WEIGHT_WIDTH(WEIGHT_WIDTH), .WEIGHT_FRACT_WIDTH(F)
  ) u_wx (
    .clk(clk), .nreset(nreset), .clr(clr), .en1_i(s1_en), .en2_i(s2_en),
    .t_i(s0_tx_q), .mode_i(s0_mode_q), .weights_o(wx)
  );

  dc_ipu_filter_kernel_weights #(
    .TAPS(TAPS), .WEIGHT_WIDTH(WEIGHT_WIDTH), .WEIGHT_FRACT_WIDTH(F)
  ) u_wy (
    .clk(clk), .nreset(nreset), .clr(clr), .en1_i(s1_en), .en2_i(s2_en),
    .t_i(s0_ty_q), .mode_i(s0_mode_q), .weights_o(wy)
  );

  assign in_ready      = in_rdy_q;
  assign out_valid     = out_vld_q;
  assign out_texels    = out_tex_q;
  assign out_weights_x = wx;
  assign out_weights_y = wy;

endmodule

// File: tb/tb_dc_ipu_filter_weight_stage.sv
// Self-checking bench for dc_ipu_filter_weight_stage (default parameters).
// Expected weights come from the kernel formulas evaluated with integer
// arithmetic; a queue of accepted beats gives the expected output order.
module tb_dc_ipu_filter_weight_stage;

  localparam int TAPS = 4, CH = 3, RGBW = 8, CW = 6, WW = 12, WF = 8;
  localparam int TEX_W = TAPS * TAPS * CH * RGBW;
  localparam int WV    = TAPS * WW;
  localparam int ONE   = 1 << WF;

  logic             clk = 1'b0, nreset, clr, in_valid, in_ready, out_valid, out_ready;
  logic [1:0]       mode;
  logic [TEX_W-1:0] in_texels, out_texels;
  logic [CW-1:0]    coeff_x, coeff_y;
  logic [WV-1:0]    out_weights_x, out_weights_y;

  always #5 clk = ~clk;

  dc_ipu_filter_weight_stage #(
    .TAPS(TAPS), .CHANNELS(CH), .RGB_WIDTH(RGBW), .COEFF_WIDTH(CW),
    .WEIGHT_WIDTH(WW), .WEIGHT_FRACT_WIDTH(WF)
  ) dut (
    .clk(clk), .nreset(nreset), .clr(clr), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_texels(in_texels),
    .coeff_x(coeff_x), .coeff_y(coeff_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_texels(out_texels),
    .out_weights_x(out_weights_x), .out_weights_y(out_weights_y)
  );

  typedef struct {
    logic [TEX_W-1:0] tex;
    logic [WV-1:0]    wx;
    logic [WV-1:0]    wy;
  } beat_t;

  beat_t            exp_q[$];
  int               errors = 0, checks = 0, npop = 0;
  logic             stalled = 1'b0;
  logic [TEX_W-1:0] p_tex;
  logic [WV-1:0]    p_wx, p_wy;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++; $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [WV-1:0] obs, input logic [WV-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++; $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chkt(input string tag, input logic [TEX_W-1:0] obs, input logic [TEX_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++; $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int fl2(input int v);   // floor(v / 2)
    return (v >= 0) ? v / 2 : -((-v + 1) / 2);
  endfunction

  function automatic logic [WV-1:0] pack4(input int a, input int b, input int c, input int d);
    logic [WV-1:0] r;
    r = {WW'(d), WW'(c), WW'(b), WW'(a)};
    return r;
  endfunction

  // Reference weights straight from the kernel definitions
  function automatic logic [WV-1:0] ref_w(input int coeff, input int md);
    int t, t2, t3;
    int w[4];
    t = coeff * (1 << (WF - CW));
    w = '{0, 0, 0, 0};
    if (md == 0) begin
      if (t < ONE / 2) w[1] = ONE; else w[2] = ONE;
    end else if (md == 2) begin
      t2 = (t * t) / ONE;
      t3 = (t * t * t) / (ONE * ONE);
      w[0] = fl2(-t3 + 2 * t2 - t);
      w[2] = fl2(-3 * t3 + 4 * t2 + t);
      w[3] = fl2(t3 - t2);
      w[1] = ONE - w[0] - w[2] - w[3];
    end else begin
      w[1] = ONE - t; w[2] = t;
    end
    for (int i = 0; i < 4; i++) begin
      if (w[i] > 2047) w[i] = 2047;
      if (w[i] < -2048) w[i] = -2048;
    end
    return pack4(w[0], w[1], w[2], w[3]);
  endfunction

  function automatic logic [TEX_W-1:0] mk_tex(input int base);
    logic [TEX_W-1:0] r;
    for (int j = 0; j < TEX_W / 8; j++) r[j*8 +: 8] = 8'(base + j);
    return r;
  endfunction

  task automatic new_beat(input int base);
    in_texels = mk_tex(base);
    coeff_x   = CW'($urandom_range(0, 63));
    coeff_y   = CW'($urandom_range(0, 63));
    mode      = 2'($urandom_range(0, 3));
  endtask

  // One clock: called at the falling edge with inputs already driven.
  // Checks the current outputs, records the handshakes of the coming edge.
  task automatic cyc();
    beat_t b;
    #1;
    chk1("in_ready_occ", in_ready, exp_q.size() != 4);
    if (out_valid) chk1("out_valid_owed", exp_q.size() != 0, 1'b1);
    if (stalled) begin
      chk1("hold_valid", out_valid, 1'b1);
      chkt("hold_tex", out_texels, p_tex);
      chkw("hold_wx", out_weights_x, p_wx);
      chkw("hold_wy", out_weights_y, p_wy);
    end
    if (clr) begin
      exp_q.delete();
      stalled = 1'b0;
    end else begin
      if (out_valid && out_ready && exp_q.size() != 0) begin
        b = exp_q.pop_front();
        npop++;
        chkt("sb_tex", out_texels, b.tex);
        chkw("sb_wx", out_weights_x, b.wx);
        chkw("sb_wy", out_weights_y, b.wy);
      end
      if (in_valid && in_ready) begin
        b.tex = in_texels;
        b.wx  = ref_w(int'(coeff_x), int'(mode));
        b.wy  = ref_w(int'(coeff_y), int'(mode));
        exp_q.push_back(b);
      end
      stalled = out_valid && !out_ready;
      p_tex = out_texels; p_wx = out_weights_x; p_wy = out_weights_y;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Single beat through an idle pipe: latency, literal weights, unit sum
  task automatic single(input string tag, input int cx, input int cy, input int md,
                        input logic [WV-1:0] ewx, input logic [WV-1:0] ewy);
    int sx, sy;
    out_ready = 1'b1; in_valid = 1'b1;
    coeff_x = CW'(cx); coeff_y = CW'(cy); mode = 2'(md);
    in_texels = mk_tex($urandom_range(0, 255));
    chk1({tag, "_rdy"}, in_ready, 1'b1);
    cyc();
    in_valid = 1'b0;
    chk1({tag, "_lat1"}, out_valid, 1'b0); cyc();
    chk1({tag, "_lat2"}, out_valid, 1'b0); cyc();
    chk1({tag, "_lat3"}, out_valid, 1'b1);
    chkw({tag, "_wx"}, out_weights_x, ewx);
    chkw({tag, "_wy"}, out_weights_y, ewy);
    sx = 0; sy = 0;
    for (int i = 0; i < TAPS; i++) begin
      sx += $signed(out_weights_x[i*WW +: WW]);
      sy += $signed(out_weights_y[i*WW +: WW]);
    end
    chk1({tag, "_sumx"}, sx == ONE, 1'b1);
    chk1({tag, "_sumy"}, sy == ONE, 1'b1);
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int   sent, ncyc, pop0;
    logic acc;
    nreset = 1'b0; clr = 1'b0; mode = '0; in_valid = 1'b0; in_texels = '0;
    coeff_x = '0; coeff_y = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_in_ready", in_ready, 1'b1);
    chkt("rst_tex", out_texels, '0);
    chkw("rst_wx", out_weights_x, '0);
    chkw("rst_wy", out_weights_y, '0);
    nreset = 1'b1;
    @(negedge clk);

    // Directed kernels (x and y differ to expose axis swaps)
    single("cub_t0",   0, 32, 2, pack4(0, 256, 0, 0),   pack4(-16, 144, 144, -16));
    single("cub_half", 32, 0, 2, pack4(-16, 144, 144, -16), pack4(0, 256, 0, 0));
    single("bil",      48, 16, 1, pack4(0, 64, 192, 0),  pack4(0, 192, 64, 0));
    single("rsvd",     16, 48, 3, pack4(0, 192, 64, 0),  pack4(0, 64, 192, 0));
    single("near",     31, 32, 0, pack4(0, 256, 0, 0),   pack4(0, 0, 256, 0));

    // 20-beat stream under random backpressure
    sent = 0; ncyc = 0; pop0 = npop;
    in_valid = 1'b1; new_beat(0);
    while ((sent < 20 || exp_q.size() != 0) && ncyc < 400) begin
      out_ready = 1'($urandom_range(0, 1));
      acc = in_valid && in_ready;
      cyc();
      ncyc++;
      if (acc) begin
        sent++;
        if (sent < 20) new_beat(sent); else in_valid = 1'b0;
      end
    end
    chk1("stream_done", sent == 20 && exp_q.size() == 0, 1'b1);
    chk1("stream_count", (npop - pop0) == 20, 1'b1);

    // Flush with three beats in flight; a simultaneous input beat is dropped
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; new_beat(40 + k);
      cyc();
    end
    clr = 1'b1; in_valid = 1'b1; new_beat(60);
    cyc();
    clr = 1'b0; in_valid = 1'b0;
    chk1("clr_out_valid", out_valid, 1'b0);
    chk1("clr_in_ready", in_ready, 1'b1);
    for (int k = 0; k < 5; k++) begin
      chk1("clr_no_stale", out_valid, 1'b0);
      cyc();
    end
    single("post_clr", 8, 56, 2, ref_w(8, 2), ref_w(56, 2));

    // Asynchronous reset in the middle of traffic
    in_valid = 1'b1; new_beat(80);
    for (int k = 0; k < 8; k++) begin
      out_ready = 1'($urandom_range(0, 1));
      acc = in_valid && in_ready;
      cyc();
      if (acc) new_beat(80 + k);
    end
    #2 nreset = 1'b0;
    #1;
    chk1("arst_out_valid", out_valid, 1'b0);
    chk1("arst_in_ready", in_ready, 1'b1);
    exp_q.delete();
    stalled = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);
    single("post_rst", 63, 1, 1, pack4(0, 4, 252, 0), pack4(0, 252, 4, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
